// File: rtl/mod_n_count_decoder.sv
// Observer for a sampled mod-N up/down counter: classifies each valid sample as
// up/down/hold/illegal relative to the previous one, counts wraps, flags errors.
module mod_n_count_decoder #(
    parameter int WIDTH  = 2,
    parameter int N      = 3,
    parameter int WRAP_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic [WIDTH-1:0]  i_q,
    input  logic              i_clr_err,
    output logic [2:0]        o_state,
    output logic              o_step_valid,
    output logic              o_err,
    output logic              o_err_sticky,
    output logic [WRAP_W-1:0] o_up_wraps,
    output logic [WRAP_W-1:0] o_dn_wraps
);
    typedef enum logic [2:0] {
        S_UNSYNC = 3'b000,
        S_DOWN   = 3'b010,
        S_UP     = 3'b011,
        S_ERROR  = 3'b100,
        S_HOLD   = 3'b111
    } state_e;

    // One extra bit so N == 2^WIDTH is representable for the range check.
    localparam logic [WIDTH:0]    N_EXT    = (WIDTH+1)'(N);
    localparam logic [WIDTH-1:0]  NM1      = WIDTH'(N-1);
    localparam logic [WRAP_W-1:0] WRAP_MAX = '1;

    logic [1:0]        rst_sync_q;
    logic              rst_n;
    state_e            state_q;
    logic [WIDTH-1:0]  prev_q;
    logic              has_prev_q;
    logic              step_valid_q, err_q, sticky_q;
    logic [WRAP_W-1:0] up_wraps_q, dn_wraps_q;

    logic              in_range, at_top, at_zero, is_hold, is_up, is_dn, err_set;
    logic [WIDTH-1:0]  up_succ, dn_succ;

    // Assert asynchronously, release two clock edges later.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) rst_sync_q <= '0;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    always_comb begin
        in_range = {1'b0, i_q} < N_EXT;
        at_top   = (prev_q == NM1);
        at_zero  = (prev_q == '0);
        up_succ  = at_top  ? '0  : prev_q + WIDTH'(1);
        dn_succ  = at_zero ? NM1 : prev_q - WIDTH'(1);
        is_hold  = (i_q == prev_q);
        is_up    = (i_q == up_succ);
        is_dn    = (i_q == dn_succ);
        err_set  = i_valid && (!in_range || (has_prev_q && !is_hold && !is_up && !is_dn));
    end

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_UNSYNC;
            prev_q       <= '0;
            has_prev_q   <= 1'b0;
            step_valid_q <= 1'b0;
            err_q        <= 1'b0;
            sticky_q     <= 1'b0;
            up_wraps_q   <= '0;
            dn_wraps_q   <= '0;
        end else begin
            step_valid_q <= 1'b0;
            err_q        <= 1'b0;
            if (i_valid) begin
                if (!in_range) begin
                    state_q    <= S_ERROR;
                    err_q      <= 1'b1;
                    has_prev_q <= 1'b0;
                end else if (!has_prev_q) begin
                    prev_q     <= i_q;
                    has_prev_q <= 1'b1;
                    if (state_q != S_ERROR) state_q <= S_UNSYNC;
                end else begin
                    step_valid_q <= 1'b1;
                    prev_q       <= i_q;
                    if (is_hold) begin
                        state_q <= S_HOLD;
                    end else if (is_up) begin
                        state_q <= S_UP;
                        if (at_top && up_wraps_q != WRAP_MAX) up_wraps_q <= up_wraps_q + WRAP_W'(1);
                    end else if (is_dn) begin
                        state_q <= S_DOWN;
                        if (at_zero && dn_wraps_q != WRAP_MAX) dn_wraps_q <= dn_wraps_q + WRAP_W'(1);
                    end else begin
                        state_q <= S_ERROR;
                        err_q   <= 1'b1;
                    end
                end
            end
            // A new error outranks a simultaneous clear.
            if (err_set)        sticky_q <= 1'b1;
            else if (i_clr_err) sticky_q <= 1'b0;
        end
    end

    assign o_state      = state_q;
    assign o_step_valid = step_valid_q;
    assign o_err        = err_q;
    assign o_err_sticky = sticky_q;
    assign o_up_wraps   = up_wraps_q;
    assign o_dn_wraps   = dn_wraps_q;
endmodule

// File: tb/tb_mod_n_count_decoder.sv
// Scoreboard bench: driver pushes model expectations, negedge monitor pops and compares.
module tb_mod_n_count_decoder;
    localparam int WIDTH  = 3;
    localparam int N      = 5;
    localparam int WRAP_W = 2;
    localparam int WMAX   = (1 << WRAP_W) - 1;

    logic              clk, i_rst_n, i_valid, i_clr_err;
    logic [WIDTH-1:0]  i_q;
    logic [2:0]        o_state;
    logic              o_step_valid, o_err, o_err_sticky;
    logic [WRAP_W-1:0] o_up_wraps, o_dn_wraps;

    mod_n_count_decoder #(.WIDTH(WIDTH), .N(N), .WRAP_W(WRAP_W)) dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_q(i_q),
        .i_clr_err(i_clr_err), .o_state(o_state), .o_step_valid(o_step_valid),
        .o_err(o_err), .o_err_sticky(o_err_sticky),
        .o_up_wraps(o_up_wraps), .o_dn_wraps(o_dn_wraps)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int st; int sv; int er; int sk; int uw; int dw;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    // Reference model state
    int m_state, m_prev, m_has, m_sk, m_uw, m_dw, m_sv, m_er;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, ".state"},  int'(o_state),      e.st);
        chk({tag, ".step"},   int'(o_step_valid), e.sv);
        chk({tag, ".err"},    int'(o_err),        e.er);
        chk({tag, ".sticky"}, int'(o_err_sticky), e.sk);
        chk({tag, ".upw"},    int'(o_up_wraps),   e.uw);
        chk({tag, ".dnw"},    int'(o_dn_wraps),   e.dw);
    endtask

    function automatic exp_t snap();
        exp_t e;
        e.st = m_state; e.sv = m_sv; e.er = m_er;
        e.sk = m_sk;    e.uw = m_uw; e.dw = m_dw;
        return e;
    endfunction

    task automatic model_reset();
        m_state = 0; m_prev = 0; m_has = 0; m_sk = 0;
        m_uw = 0; m_dw = 0; m_sv = 0; m_er = 0;
    endtask

    task automatic model_step(input int v, input int q, input int clr);
        m_sv = 0; m_er = 0;
        if (v != 0) begin
            if (q >= N) begin
                m_state = 4; m_er = 1; m_has = 0;
            end else if (m_has == 0) begin
                m_prev = q; m_has = 1;
                if (m_state != 4) m_state = 0;
            end else begin
                m_sv = 1;
                if (q == m_prev) m_state = 7;
                else if (q == (m_prev + 1) % N) begin
                    m_state = 3;
                    if (m_prev == N - 1 && m_uw < WMAX) m_uw++;
                end else if (q == (m_prev + N - 1) % N) begin
                    m_state = 2;
                    if (m_prev == 0 && m_dw < WMAX) m_dw++;
                end else begin
                    m_state = 4; m_er = 1;
                end
                m_prev = q;
            end
        end
        if (m_er != 0)    m_sk = 1;
        else if (clr != 0) m_sk = 0;
    endtask

    task automatic drive(input int v, input int q, input int clr);
        @(negedge clk);
        i_valid = (v != 0); i_q = q[WIDTH-1:0]; i_clr_err = (clr != 0);
        @(posedge clk);
        #1;
        model_step(v, q, clr);
        sb.push_back(snap());
    endtask

    task automatic seq(input int vals[$]);
        foreach (vals[k]) drive(1, vals[k], 0);
    endtask

    task automatic do_reset(input string tag);
        i_rst_n = 1'b0;
        sb.delete();
        model_reset();
        #1;
        chk_all(tag, snap());
        @(negedge clk);
        i_rst_n = 1'b1;
        for (int k = 0; k < 3; k++) drive(0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (i_rst_n && sb.size() > 0) chk_all("mon", sb.pop_front());
    end

    initial begin
        i_rst_n = 1'b1; i_valid = 1'b0; i_q = '0; i_clr_err = 1'b0;
        model_reset();
        #3;
        do_reset("rst0");

        seq('{0, 1, 2, 3, 4, 0, 1});              // seeding then up with one wrap
        seq('{1, 0, 4, 3, 2, 1, 0, 4});           // down, two wraps
        seq('{1, 1});                             // hold
        for (int k = 0; k < 3; k++) drive(0, 6, 1 - k % 2); // gap, input ignored
        drive(1, 2, 0);                           // up after gap
        seq('{6, 1, 0});                          // out of range, reseed, down
        drive(0, 0, 1);                           // clear sticky
        seq('{0, 3});                             // illegal step
        drive(1, 1, 1);                           // illegal step with clear: set wins
        drive(0, 0, 0);
        drive(0, 0, 1);                           // clear alone
        drive(0, 0, 0);

        do_reset("rst1");
        for (int k = 0; k < 400; k++) begin
            int r, q, v, c;
            r = $urandom_range(0, 9);
            if (r < 4)      q = (m_prev + 1) % N;
            else if (r < 7) q = (m_prev + N - 1) % N;
            else if (r < 8) q = m_prev;
            else if (r < 9) q = $urandom_range(0, 7);
            else            q = $urandom_range(0, N - 1);
            v = ($urandom_range(0, 3) != 0) ? 1 : 0;
            c = ($urandom_range(0, 7) == 0) ? 1 : 0;
            drive(v, q, c);
        end

        do_reset("rst2");
        drive(1, 0, 0);
        for (int w = 0; w < 5; w++) seq('{1, 2, 3, 4, 0}); // five up-wraps, saturates at 3
        drive(0, 0, 0);
        drive(0, 0, 0);

        // Mid-cycle asynchronous reset: outputs must drop before any clock edge.
        #2;
        do_reset("rst_async");
        drive(0, 0, 0);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mod_n_count_decoder.md
# mod_n_count_decoder

Observer for the sampled output of a mod-N up/down counter. It takes one counter value per valid cycle and reconstructs the counter's behaviour: direction of motion (up, down or hold), up and down wrap-around events, and illegal transitions. It sits downstream of the mod-N counter, at the receiving end of its count bus, and feeds status and self-check logic.

## Interface
- `WIDTH`, default 2: count bus width.
- `N`, default 3: modulus. Legal range is 3 ≤ N ≤ 2^WIDTH.
- `WRAP_W`, default 8: width of each wrap counter.
- `i_clk`: input, 1 bit. Single clock, rising edge.
- `i_rst_n`: input, 1 bit. Asynchronous, active-low reset.
- `i_valid`: input, 1 bit. `i_q` holds a new sample this cycle.
- `i_q`: input, WIDTH bits. Sampled counter value.
- `i_clr_err`: input, 1 bit. Clears `o_err_sticky`.
- `o_state`: output, 3 bits. Decoded state (encodings under Operation).
- `o_step_valid`: output, 1 bit. One-cycle pulse; a step was classified.
- `o_err`: output, 1 bit. One-cycle pulse on an illegal sample.
- `o_err_sticky`: output, 1 bit. Latched error flag.
- `o_up_wraps`: output, WRAP_W bits. Count of N-1→0 steps, saturating.
- `o_dn_wraps`: output, WRAP_W bits. Count of 0→N-1 steps, saturating.

## Operation
**States and encodings**
- UNSYNC = 3'b000
- DOWN = 3'b010
- UP = 3'b011
- ERROR = 3'b100
- HOLD = 3'b111

**Internal registers**
- `prev_q` (WIDTH bits): last accepted sample.
- `has_prev`: a reference sample exists.

**Per cycle with `i_valid` = 1**
- If `i_q` ≥ N (out of range):
  - state → ERROR; `o_err` pulses.
  - `has_prev` cleared; `prev_q` unchanged.
- If in range and `has_prev` = 0:
  - Load `prev_q` = `i_q` and set `has_prev`.
  - State → UNSYNC, except ERROR, which persists until the first classified step.
  - No step and no error reported.
- If in range and `has_prev` = 1, classify against `prev_q`:
  - `i_q` == `prev_q` → HOLD.
  - `i_q` == (`prev_q` == N-1 ? 0 : `prev_q`+1) → UP. If `prev_q` == N-1, increment `o_up_wraps`.
  - `i_q` == (`prev_q` == 0 ? N-1 : `prev_q`-1) → DOWN. If `prev_q` == 0, increment `o_dn_wraps`.
  - Anything else → ERROR and `o_err` pulses.
  - In all four cases: `o_step_valid` pulses and `prev_q` = `i_q`. After an illegal step, `prev_q` re-seeds from that sample.
- N ≥ 3 guarantees that the up and down successors differ, so classification is unambiguous.

**Per cycle with `i_valid` = 0**
- State, `prev_q` and the counters hold.
- `o_step_valid` = 0 and `o_err` = 0.

**Wrap counters**
- Saturate at 2^WRAP_W − 1; they never roll over.
- Cleared only by reset.

**Sticky error**
- Set by any `o_err` pulse.
- Cleared by `i_clr_err`.
- If a set and a clear occur in the same cycle, the set wins.

**Arithmetic**
- All comparisons are done at WIDTH bits on values already checked to be < N.
- No reliance on natural 2^WIDTH wrap.

## Timing
- Every output is registered.
- Response latency is 1 cycle: a sample presented at edge k is reflected in the outputs after edge k.
- Reset values, applied asynchronously on `i_rst_n` = 0:
  - `o_state` = UNSYNC
  - `o_step_valid` = 0, `o_err` = 0, `o_err_sticky` = 0
  - `o_up_wraps` = 0, `o_dn_wraps` = 0
  - `has_prev` = 0, `prev_q` = 0
- Reset deassertion is synchronous to `i_clk` (release path through the standard reset synchroniser).
- Reset mid-stream discards `prev_q`. The first valid sample after reset only seeds.
- Back-to-back valid samples are accepted every cycle, with no stall.

## Test plan
- **Reset, then seeding.** Stimulus: reset, then `i_q` = 0, 1, 2, 0, 1 on consecutive valid cycles (N=3). Required response: after reset all outputs 0 and state UNSYNC; first sample gives UNSYNC with no step; then UP ×4 with `o_step_valid` pulses; `o_up_wraps` = 1 after the 2→0 step.
- **Down with wrap.** Stimulus: `i_q` = 1, 0, 2, 1, 0, 2. Required response: DOWN on every step; `o_dn_wraps` = 2; `o_up_wraps` unchanged.
- **Hold and gaps.** Stimulus: `i_q` = 1, 1; then `i_valid` = 0 for 3 cycles; then 2. Required response: HOLD held through the gap with no pulses during it; then UP.
- **Illegal inputs.** Stimulus: WIDTH=2, N=3; `i_q` = 3 (out of range), then a legal 1, then 0. Required response: ERROR with one `o_err` pulse; 1 only seeds; 0 → DOWN; `o_err_sticky` = 1 throughout.
- **Illegal step and error clear.** Stimulus: N=5, WIDTH=3; `i_q` = 0 then 3; pulse `i_clr_err` in the same cycle as a second illegal step. Required response: ERROR; sticky remains 1; a later `i_clr_err` alone clears it to 0.
- **Saturation and async reset.** Stimulus: WRAP_W=2; drive 5 up-wraps; then assert `i_rst_n` low mid-cycle. Required response: `o_up_wraps` holds at 3; on reset assertion all outputs return to reset values immediately, without waiting for a clock edge.
